// File: rtl/branch_predictor_if.sv
// Predictor bus between the IF/ID pipeline (master) and the BTB (slave).
// Carries the per-cycle lookup, the resolved-branch update and the
// misprediction outputs. CNT_W must match the predictor's CNT_W.
interface branch_predictor_if #(
  parameter int CNT_W = 16
);
  logic [31:0]      lookup_pc;
  logic             pred_hit;
  logic             pred_taken;
  logic [31:0]      pred_target;
  logic             update_en;
  logic [31:0]      update_pc;
  logic             update_taken;
  logic [31:0]      update_target;
  logic             update_pred_taken;
  logic [31:0]      update_pred_target;
  logic             mispredict;
  logic [CNT_W-1:0] mispredict_cnt;

  modport master (
    output lookup_pc, update_en, update_pc, update_taken, update_target,
           update_pred_taken, update_pred_target,
    input  pred_hit, pred_taken, pred_target, mispredict, mispredict_cnt
  );

  modport slave (
    input  lookup_pc, update_en, update_pc, update_taken, update_target,
           update_pred_taken, update_pred_target,
    output pred_hit, pred_taken, pred_target, mispredict, mispredict_cnt
  );
endinterface

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with per-entry saturating direction counters.
// Lookup is combinational from flops (zero latency); updates land at the
// clock edge and are visible from the following cycle (no bypass).
module branch_predictor #(
  parameter int IDX_W = 6,
  parameter int TAG_W = 8,
  parameter int CTR_W = 2,
  parameter int CNT_W = 16
) (
  input logic               clk,
  input logic               rst,
  branch_predictor_if.slave bp
);
  localparam int DEPTH = 2 ** IDX_W;
  localparam logic [CTR_W-1:0] CTR_MAX = {CTR_W{1'b1}};
  // Weakly taken is the MSB alone; weakly not-taken is one below it
  // (which collapses to 0 when CTR_W=1, leaving a last-outcome bit).
  localparam logic [CTR_W-1:0] CTR_WT  = CTR_W'(1) << (CTR_W - 1);
  localparam logic [CTR_W-1:0] CTR_WNT = CTR_WT - CTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [DEPTH-1:0]             valid_q;
  logic [DEPTH-1:0][TAG_W-1:0]  tag_q;
  logic [DEPTH-1:0][CTR_W-1:0]  ctr_q;
  logic [DEPTH-1:0][31:0]       target_q;
  logic [CNT_W-1:0]             cnt_q;

  logic [IDX_W-1:0] l_idx, u_idx;
  logic [TAG_W-1:0] l_tag, u_tag;
  logic             l_hit, u_hit, l_taken;

  assign l_idx = bp.lookup_pc[IDX_W+1:2];
  assign l_tag = bp.lookup_pc[IDX_W+TAG_W+1:IDX_W+2];
  assign u_idx = bp.update_pc[IDX_W+1:2];
  assign u_tag = bp.update_pc[IDX_W+TAG_W+1:IDX_W+2];

  assign l_hit   = valid_q[l_idx] && (tag_q[l_idx] == l_tag);
  assign l_taken = l_hit && ctr_q[l_idx][CTR_W-1];
  assign u_hit   = valid_q[u_idx] && (tag_q[u_idx] == u_tag);

  assign bp.pred_hit       = l_hit;
  assign bp.pred_taken     = l_taken;
  assign bp.pred_target    = l_taken ? target_q[l_idx] : bp.lookup_pc + 32'd4;
  assign bp.mispredict     = bp.update_en &&
                             ((bp.update_taken != bp.update_pred_taken) ||
                              (bp.update_taken &&
                               (bp.update_target != bp.update_pred_target)));
  assign bp.mispredict_cnt = cnt_q;

  // Table update: train on hit, allocate (evicting) on taken miss, ignore
  // not-taken miss. Reset wins over a concurrent update.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        ctr_q[i]    <= CTR_WNT;
        target_q[i] <= '0;
      end
    end else if (bp.update_en) begin
      if (u_hit) begin
        if (bp.update_taken) begin
          if (ctr_q[u_idx] != CTR_MAX) ctr_q[u_idx] <= ctr_q[u_idx] + CTR_W'(1);
          target_q[u_idx] <= bp.update_target;
        end else if (ctr_q[u_idx] != '0) begin
          ctr_q[u_idx] <= ctr_q[u_idx] - CTR_W'(1);
        end
      end else if (bp.update_taken) begin
        valid_q[u_idx]  <= 1'b1;
        tag_q[u_idx]    <= u_tag;
        ctr_q[u_idx]    <= CTR_WT;
        target_q[u_idx] <= bp.update_target;
      end
    end
  end

  // Saturating misprediction statistic.
  always_ff @(posedge clk) begin
    if (rst)                                  cnt_q <= '0;
    else if (bp.mispredict && cnt_q != CNT_MAX) cnt_q <= cnt_q + CNT_W'(1);
  end
endmodule

// File: tb/tb_branch_predictor.sv
// Table-driven bench for branch_predictor (IDX_W=6, TAG_W=8, CTR_W=2,
// CNT_W=2). Combinational outputs are compared just before each edge;
// the expected post-edge mispredict_cnt is queued and checked after it.
module tb_branch_predictor;
  localparam int CNT_W = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  branch_predictor_if #(.CNT_W(CNT_W)) bp ();

  branch_predictor #(.IDX_W(6), .TAG_W(8), .CTR_W(2), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bp  (bp)
  );

  typedef struct {
    logic        r;
    logic [31:0] lpc;
    logic        ue;
    logic [31:0] upc;
    logic        ut;
    logic [31:0] utgt;
    logic        upt;
    logic [31:0] uptgt;
    logic        e_hit;
    logic        e_tk;
    logic [31:0] e_tgt;
    logic        e_mis;
    logic [CNT_W-1:0] e_cnt;  // value after this cycle's edge
  } vec_t;

  int total = 0;
  int passed = 0;
  logic [CNT_W-1:0] cnt_q[$];

  task automatic chk(input string name, input int row, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s row %0d: got 0x%0h expected 0x%0h", name, row, act, exp);
  endtask

  function automatic vec_t mk(logic r, logic [31:0] lpc, logic ue, logic [31:0] upc,
                              logic ut, logic [31:0] utgt, logic upt,
                              logic [31:0] uptgt, logic e_hit, logic e_tk,
                              logic [31:0] e_tgt, logic e_mis, logic [CNT_W-1:0] e_cnt);
    vec_t v;
    v.r = r; v.lpc = lpc; v.ue = ue; v.upc = upc; v.ut = ut; v.utgt = utgt;
    v.upt = upt; v.uptgt = uptgt; v.e_hit = e_hit; v.e_tk = e_tk;
    v.e_tgt = e_tgt; v.e_mis = e_mis; v.e_cnt = e_cnt;
    return v;
  endfunction

  task automatic step(input vec_t v, input int row);
    logic [CNT_W-1:0] exp_cnt;
    @(negedge clk);
    rst                   = v.r;
    bp.lookup_pc          = v.lpc;
    bp.update_en          = v.ue;
    bp.update_pc          = v.upc;
    bp.update_taken       = v.ut;
    bp.update_target      = v.utgt;
    bp.update_pred_taken  = v.upt;
    bp.update_pred_target = v.uptgt;
    #1;
    chk("pred_hit",    row, 32'(bp.pred_hit),   32'(v.e_hit));
    chk("pred_taken",  row, 32'(bp.pred_taken), 32'(v.e_tk));
    chk("pred_target", row, bp.pred_target,     v.e_tgt);
    chk("mispredict",  row, 32'(bp.mispredict), 32'(v.e_mis));
    cnt_q.push_back(v.e_cnt);
    @(posedge clk);
    #1;
    if (cnt_q.size() == 0) begin
      total++;
      $display("FAIL scoreboard row %0d: queue empty, expected one entry", row);
    end else begin
      exp_cnt = cnt_q.pop_front();
      chk("mispredict_cnt", row, 32'(bp.mispredict_cnt), 32'(exp_cnt));
    end
  endtask

  vec_t tbl[$];

  initial begin
    // r  lookup        ue upc   ut utgt    upt uptgt    hit tk tgt         mis cnt
    tbl.push_back(mk(0, 32'h40,  0, 0,     0, 0,       0, 0,       0, 0, 32'h44,   0, 0)); // 0 reset state
    tbl.push_back(mk(0, 32'h40,  1, 32'h40,1, 32'h100, 0, 0,       0, 0, 32'h44,   1, 1)); // 1 allocate
    tbl.push_back(mk(0, 32'h40,  0, 0,     0, 0,       0, 0,       1, 1, 32'h100,  0, 1)); // 2 ctr=2
    tbl.push_back(mk(0, 32'h40,  1, 32'h40,1, 32'h100, 1, 32'h100, 1, 1, 32'h100,  0, 1)); // 3 ctr->3
    tbl.push_back(mk(0, 32'h40,  1, 32'h40,1, 32'h100, 1, 32'h100, 1, 1, 32'h100,  0, 1)); // 4 sat
    tbl.push_back(mk(0, 32'h40,  1, 32'h40,1, 32'h100, 1, 32'h100, 1, 1, 32'h100,  0, 1)); // 5 sat
    tbl.push_back(mk(0, 32'h40,  1, 32'h40,0, 0,       1, 32'h100, 1, 1, 32'h100,  1, 2)); // 6 ctr->2
    tbl.push_back(mk(0, 32'h40,  0, 0,     0, 0,       0, 0,       1, 1, 32'h100,  0, 2)); // 7 still taken
    tbl.push_back(mk(0, 32'h40,  1, 32'h40,0, 0,       1, 32'h100, 1, 1, 32'h100,  1, 3)); // 8 ctr->1
    tbl.push_back(mk(0, 32'h40,  0, 0,     0, 0,       0, 0,       1, 0, 32'h44,   0, 3)); // 9 not taken
    tbl.push_back(mk(0, 32'h140, 0, 0,     0, 0,       0, 0,       0, 0, 32'h144,  0, 3)); // 10 alias miss
    tbl.push_back(mk(0, 32'h140, 1, 32'h140,1,32'h300, 0, 0,       0, 0, 32'h144,  1, 3)); // 11 evict, cnt sat
    tbl.push_back(mk(0, 32'h40,  0, 0,     0, 0,       0, 0,       0, 0, 32'h44,   0, 3)); // 12 evicted
    tbl.push_back(mk(0, 32'h140, 0, 0,     0, 0,       0, 0,       1, 1, 32'h300,  0, 3)); // 13 new owner
    tbl.push_back(mk(0, 32'h80,  1, 32'h80,1, 32'h400, 1, 32'h400, 0, 0, 32'h84,   0, 3)); // 14 same-cycle
    tbl.push_back(mk(0, 32'h80,  0, 0,     0, 0,       0, 0,       1, 1, 32'h400,  0, 3)); // 15 visible now
    tbl.push_back(mk(0, 32'h80,  1, 32'h80,1, 32'h200, 1, 32'h100, 1, 1, 32'h400,  1, 3)); // 16 target change
    tbl.push_back(mk(0, 32'h80,  0, 0,     0, 0,       0, 0,       1, 1, 32'h200,  0, 3)); // 17 new target
    tbl.push_back(mk(0, 32'hC0,  1, 32'hC0,0, 0,       0, 0,       0, 0, 32'hC4,   0, 3)); // 18 miss not-taken
    tbl.push_back(mk(0, 32'hC0,  0, 0,     0, 0,       0, 0,       0, 0, 32'hC4,   0, 3)); // 19 no alloc
    tbl.push_back(mk(1, 32'h80,  1, 32'h80,1, 32'h500, 0, 0,       1, 1, 32'h200,  1, 0)); // 20 reset wins
    tbl.push_back(mk(0, 32'h80,  0, 0,     0, 0,       0, 0,       0, 0, 32'h84,   0, 0)); // 21 cleared
    tbl.push_back(mk(0, 32'h40,  0, 0,     0, 0,       0, 0,       0, 0, 32'h44,   0, 0)); // 22 cleared
    tbl.push_back(mk(0, 32'hFFFFFFFC,0,0,  0, 0,       0, 0,       0, 0, 32'h0,    0, 0)); // 23 pc+4 wrap

    rst = 1'b1;
    bp.lookup_pc = '0; bp.update_en = 1'b0; bp.update_pc = '0;
    bp.update_taken = 1'b0; bp.update_target = '0;
    bp.update_pred_taken = 1'b0; bp.update_pred_target = '0;
    repeat (2) @(posedge clk);
    #1;

    foreach (tbl[i]) step(tbl[i], i);

    // Hand sequence: allocate then a single not-taken drops to weakly
    // not-taken (ctr 2 -> 1); a later taken brings it back to taken.
    step(mk(0, 32'h100, 1, 32'h100, 1, 32'h800, 0, 0, 0, 0, 32'h104, 1, 1), 100);
    step(mk(0, 32'h100, 1, 32'h100, 0, 0, 1, 32'h800, 1, 1, 32'h800, 1, 2), 101);
    step(mk(0, 32'h100, 0, 0,       0, 0, 0, 0,       1, 0, 32'h104, 0, 2), 102);
    step(mk(0, 32'h100, 1, 32'h100, 1, 32'h900, 0, 0, 1, 0, 32'h104, 1, 3), 103);
    step(mk(0, 32'h100, 0, 0,       0, 0, 0, 0,       1, 1, 32'h900, 0, 3), 104);
    // Bubble (update_en=0) with mismatching payload must not count or train.
    step(mk(0, 32'h100, 0, 32'h100, 0, 0, 1, 32'h1, 1, 1, 32'h900, 0, 3), 105);
    step(mk(0, 32'h100, 0, 0,       0, 0, 0, 0,       1, 1, 32'h900, 0, 3), 106);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog: timeout reached, expected completion");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Direct-mapped branch target buffer with per-entry saturating direction counters, parametrised in depth, tag width and counter width.
- Sits beside the IF stage. Looked up with the fetch PC every cycle; updated from the ID stage when a branch resolves.
- Replaces the "predict not-taken, flush on every taken branch" policy: IF fetches the predicted target, and the ID-side flush fires only on a real misprediction.
- Reports a misprediction flag and keeps a saturating misprediction counter for performance measurement.

Parameters:
- IDX_W, 6, index bits; table depth = 2^IDX_W entries.
- TAG_W, 8, tag bits stored per entry.
- CTR_W, 2, direction counter width (valid range 1..4).
- CNT_W, 16, misprediction statistics counter width.

Ports:
- clk  in  1  pipeline clock
- rst  in  1  synchronous, active-high reset
- lookup_pc  in  32  fetch PC from IF
- pred_hit  out  1  valid entry with matching tag
- pred_taken  out  1  predicted taken
- pred_target  out  32  next fetch address
- update_en  in  1  branch resolved in ID this cycle
- update_pc  in  32  PC of the resolved branch
- update_taken  in  1  actual direction
- update_target  in  32  actual taken target
- update_pred_taken  in  1  prediction made for this branch, piped from IF
- update_pred_target  in  32  predicted target, piped from IF
- mispredict  out  1  flush request for IF/ID
- mispredict_cnt  out  CNT_W  saturating count of mispredictions

Behaviour:
- Address slicing:
  - idx = pc[IDX_W+1:2]
  - tag = pc[IDX_W+TAG_W+1:IDX_W+2]
  - Constraint: IDX_W+TAG_W+2 <= 32.
- Entry contents: valid (1), tag (TAG_W), ctr (CTR_W), target (32).
  - Contents are held in flops.
  - Reads are combinational, so lookup has zero latency.
- Lookup (combinational):
  - pred_hit = valid[idx] && tag[idx] == tag(lookup_pc).
  - pred_taken = pred_hit && ctr[idx][CTR_W-1].
  - pred_target = target[idx] when pred_taken, else lookup_pc+4 (32-bit wrap).
- mispredict (combinational) = update_en && (update_taken != update_pred_taken || (update_taken && update_target != update_pred_target)).
- Update, at the posedge when update_en=1, at index u = idx(update_pc):
  - Hit, taken: ctr = min(ctr+1, 2^CTR_W-1); target = update_target.
  - Hit, not taken: ctr = max(ctr-1, 0); target unchanged.
  - Miss, taken: allocate and overwrite any valid entry. Set valid=1, tag = tag(update_pc), ctr = 2^(CTR_W-1) (weakly taken), target = update_target.
  - Miss, not taken: no change.
- mispredict_cnt:
  - Increments at the posedge when mispredict=1.
  - Saturates at 2^CTR... no: saturates at 2^CNT_W-1; never wraps.
- Simultaneous lookup and update of the same index: lookup returns the pre-update contents; the new contents are visible from the next cycle. There is no bypass.
- Pipeline freeze (hazard stall): no freeze input. IF holds lookup_pc, so the outputs are stable. The pipeline must deassert update_en for bubbles so that no counter is double-updated.
- Reset:
  - Applies to all entries: valid=0, ctr = 2^(CTR_W-1)-1 (weakly not-taken), tag=0, target=0; mispredict_cnt=0.
  - Resulting outputs: pred_hit=0, pred_taken=0, pred_target = lookup_pc+4, mispredict follows its inputs.
  - Reset has priority over a concurrent update_en; that update is dropped.
- CTR_W=1: the counter degenerates to a last-outcome bit and allocation sets it to 1.

Test Plan:
- Reset, then lookup_pc=0x40: pred_hit=0, pred_taken=0, pred_target=0x44, mispredict_cnt=0.
- Update pc=0x40, taken=1, target=0x100, pred_taken=0:
  - mispredict=1 that cycle and mispredict_cnt=1 after it.
  - Next cycle, lookup 0x40 gives hit=1, taken=1, target=0x100.
- Saturation and hysteresis at 0x40 (CTR_W=2):
  - Three taken updates saturate ctr at 3.
  - One not-taken update (ctr=2) still predicts taken.
  - A second not-taken update (ctr=1) predicts not-taken, target 0x44.
- Aliasing (IDX_W=6, TAG_W=8): pc 0x40 and pc 0x140 share idx 16 with different tags.
  - After 0x40 is allocated, lookup 0x140 gives hit=0.
  - A taken update at 0x140 evicts it, after which lookup 0x40 gives hit=0.
- Same-cycle read/write: lookup and taken-allocate at 0x80 in the same cycle.
  - That cycle: hit=0.
  - Following cycle: hit=1.
- Target change and counter saturation:
  - Hit taken with update_target=0x200 while update_pred_target=0x100 gives mispredict=1.
  - With CNT_W=2, four mispredictions leave mispredict_cnt=3.
  - Asserting rst mid-sequence clears all entries and the counter on the next edge.
